// File: rtl/riscv_ctrl_pkg.sv
// riscv_ctrl_pkg: shared state encoding, opcodes, ALUOp and ImmSrc codes for the multicycle controller.
package riscv_ctrl_pkg;
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWRITE, S_MEMWB, S_EXECR, S_EXECI,
    S_ALUWB, S_JAL, S_BRANCH, S_JALR, S_JALRWB, S_UTYPE, S_ERROR
  } state_t;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_UPPER = 2'b11;
  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;
endpackage

// File: rtl/ALU_Decoder.sv
// ALU_Decoder: maps ALUOp, funct3, funct7b5 and opcode to the 4-bit ALU operation code.
module ALU_Decoder
  import riscv_ctrl_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  output logic [3:0] alu_control
);
  always_comb begin
    alu_control = 4'b0000;
    case (alu_op)
      ALUOP_SUB: alu_control = 4'b0001;
      ALUOP_FUNCT:
        case (funct3)
          3'b000: alu_control = (funct7b5 && op[5]) ? 4'b0001 : 4'b0000;
          3'b001: alu_control = 4'b1010;
          3'b010: alu_control = 4'b0101;
          3'b011: alu_control = 4'b0110;
          3'b100: alu_control = 4'b0100;
          3'b101: alu_control = funct7b5 ? 4'b1011 : 4'b1100;
          3'b110: alu_control = 4'b0011;
          3'b111: alu_control = 4'b0010;
        endcase
      ALUOP_UPPER: alu_control = (op == OP_AUIPC) ? 4'b1000 : (op == OP_LUI) ? 4'b1001 : 4'b0000;
      default: alu_control = 4'b0000;
    endcase
  end
endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: Moore FSM sequencing a multicycle RISC-V datapath with memory handshake.
module multicycle_controller
  import riscv_ctrl_pkg::*;
#(
  parameter state_t RESET_STATE = S_FETCH
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  op,
  input  logic [2:0]  funct3,
  input  logic        funct7b5,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        PCWrite,
  output logic        IRWrite,
  output logic        MemWrite,
  output logic        RegWrite,
  output logic        AdrSrc,
  output logic [1:0]  ResultSrc,
  output logic [1:0]  ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [2:0]  ImmSrc,
  output logic [3:0]  ALUControl,
  output logic        illegal,
  output logic [31:0] instret
);
  state_t      state_q, state_d;
  logic [31:0] instret_q, instret_d;
  logic [1:0]  alu_op;
  logic        pc_update, branch_taken, reg_write, ill;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RESET_STATE;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE:
        case (op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECR;
          OP_ITYPE:          state_d = S_EXECI;
          OP_JAL:            state_d = S_JAL;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JALR:           state_d = S_JALR;
          OP_AUIPC, OP_LUI:  state_d = S_UTYPE;
          default:           state_d = S_ERROR;
        endcase
      S_MEMADR:   state_d = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_d = mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWRITE: state_d = mem_ready ? S_FETCH : S_MEMWRITE;
      S_EXECR, S_EXECI, S_JAL, S_UTYPE: state_d = S_ALUWB;
      S_JALR:     state_d = S_JALRWB;
      default:    state_d = S_FETCH;
    endcase
  end
  // Error recovery returns to fetch without retiring anything.
  assign instret_d = instret_q + ((state_d == S_FETCH && state_q != S_FETCH && state_q != S_ERROR) ? 32'd1 : 32'd0);
  always_comb begin
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    alu_op    = ALUOP_ADD;
    ResultSrc = 2'b00;
    AdrSrc    = 1'b0;
    reg_write = 1'b0;
    pc_update = 1'b0;
    ill       = 1'b0;
    case (state_q)
      S_FETCH:    begin ALUSrcB = 2'b10; ResultSrc = 2'b10; pc_update = mem_ready; end
      S_DECODE:   begin ALUSrcA = 2'b01; ALUSrcB = 2'b01; end
      S_MEMADR:   begin ALUSrcA = 2'b10; ALUSrcB = 2'b01; end
      S_MEMREAD, S_MEMWRITE: AdrSrc = 1'b1;
      S_MEMWB:    begin ResultSrc = 2'b01; reg_write = 1'b1; end
      S_EXECR:    begin ALUSrcA = 2'b10; alu_op = ALUOP_FUNCT; end
      S_EXECI:    begin ALUSrcA = 2'b10; ALUSrcB = 2'b01; alu_op = ALUOP_FUNCT; end
      S_ALUWB:    reg_write = 1'b1;
      S_JAL:      begin ALUSrcA = 2'b01; ALUSrcB = 2'b10; pc_update = 1'b1; end
      S_BRANCH:   begin ALUSrcA = 2'b10; alu_op = ALUOP_SUB; end
      S_JALR:     begin ALUSrcA = 2'b10; ALUSrcB = 2'b01; ResultSrc = 2'b10; pc_update = 1'b1; end
      S_JALRWB:   begin ALUSrcA = 2'b01; ALUSrcB = 2'b10; ResultSrc = 2'b10; reg_write = 1'b1; end
      S_UTYPE:    begin ALUSrcA = 2'b01; ALUSrcB = 2'b01; alu_op = ALUOP_UPPER; end
      S_ERROR:    ill = 1'b1;
      default:    ;
    endcase
  end
  assign branch_taken = (state_q == S_BRANCH) && ((funct3 == 3'b000) ? zero : (funct3 == 3'b001) ? ~zero : 1'b0);
  // Enables are masked by rst_n so an access cut short by reset cannot commit.
  assign PCWrite  = rst_n & (pc_update | branch_taken);
  assign IRWrite  = rst_n & (state_q == S_FETCH) & mem_ready;
  assign MemWrite = rst_n & (state_q == S_MEMWRITE) & mem_ready;
  assign RegWrite = rst_n & reg_write;
  assign illegal  = rst_n & ill;
  assign instret  = instret_q;
  assign ImmSrc = (op == OP_STORE) ? IMM_S : (op == OP_BRANCH) ? IMM_B :
                  (op == OP_AUIPC || op == OP_LUI) ? IMM_U : (op == OP_JAL) ? IMM_J : IMM_I;
  ALU_Decoder u_alu_decoder (
    .alu_op      (alu_op),
    .op          (op),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .alu_control (ALUControl)
  );
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: directed instruction sequences checked cycle by cycle through a scoreboard queue.
module tb_multicycle_controller;
  typedef struct packed {
    logic pcw, irw, mw, rw, adr;
    logic [1:0] rs, asa, asb;
    logic [2:0] imm;
    logic [3:0] aluc;
    logic ill;
    logic [31:0] ir;
  } obs_t;
  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011, IT = 7'b0010011;
  localparam logic [6:0] JL = 7'b1101111, BR = 7'b1100011, LU = 7'b0110111, BAD = 7'b1111111;
  logic clk = 0, rst_n = 0;
  logic [6:0] op = LW;
  logic [2:0] funct3 = 3'b010;
  logic funct7b5 = 0, zero = 0, mem_ready = 0;
  logic PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc, illegal;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
  logic [2:0] ImmSrc;
  logic [3:0] ALUControl;
  logic [31:0] instret;
  obs_t act, exp_q[$];
  string nm_q[$];
  int total = 0, bad = 0;
  multicycle_controller dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5), .zero(zero),
    .mem_ready(mem_ready), .PCWrite(PCWrite), .IRWrite(IRWrite), .MemWrite(MemWrite),
    .RegWrite(RegWrite), .AdrSrc(AdrSrc), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .ALUControl(ALUControl), .illegal(illegal), .instret(instret)
  );
  always #5 clk = ~clk;
  assign act = '{PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc, ResultSrc, ALUSrcA, ALUSrcB,
                 ImmSrc, ALUControl, illegal, instret};
  function automatic obs_t e(input logic pcw, irw, mw, rw, adr, input logic [1:0] rs, asa, asb,
                             input logic [2:0] imm, input logic [3:0] aluc, input logic ill, input int ir);
    return '{pcw, irw, mw, rw, adr, rs, asa, asb, imm, aluc, ill, ir};
  endfunction
  task automatic check(input string nm, input obs_t a, input obs_t x);
    total++;
    if (a !== x) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, a, x);
    end
  endtask
  task automatic check_en(input string nm, input logic [36:0] a, input logic [36:0] x);
    total++;
    if (a !== x) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, a, x);
    end
  endtask
  task automatic cyc(input string nm, input logic [6:0] o, input logic [2:0] f3, input logic f7,
                     input logic z, input logic mr, input obs_t x);
    @(posedge clk);
    #1;
    op = o; funct3 = f3; funct7b5 = f7; zero = z; mem_ready = mr;
    exp_q.push_back(x);
    nm_q.push_back(nm);
  endtask
  always @(negedge clk)
    if (exp_q.size() > 0) check(nm_q.pop_front(), act, exp_q.pop_front());
  initial begin
    #3;
    check("reset_idle", act, e(0,0,0,0,0,2,0,2,0,0,0,0));
    mem_ready = 1;
    #1;
    check("reset_mr_gated", act, e(0,0,0,0,0,2,0,2,0,0,0,0));
    mem_ready = 0;
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 3; i++) cyc("fetch_wait", LW, 3'd2, 0, 0, 0, e(0,0,0,0,0,2,0,2,0,0,0,0));
    cyc("fetch_go", LW, 3'd2, 0, 0, 1, e(1,1,0,0,0,2,0,2,0,0,0,0));
    cyc("lw_dec",   LW, 3'd2, 0, 0, 1, e(0,0,0,0,0,0,1,1,0,0,0,0));
    cyc("lw_adr",   LW, 3'd2, 0, 0, 1, e(0,0,0,0,0,0,2,1,0,0,0,0));
    cyc("lw_read",  LW, 3'd2, 0, 0, 1, e(0,0,0,0,1,0,0,0,0,0,0,0));
    cyc("lw_wb",    LW, 3'd2, 0, 0, 1, e(0,0,0,1,0,1,0,0,0,0,0,0));
    cyc("beq_fetch", BR, 3'd0, 0, 1, 1, e(1,1,0,0,0,2,0,2,2,0,0,1));
    cyc("beq_dec",   BR, 3'd0, 0, 1, 1, e(0,0,0,0,0,0,1,1,2,0,0,1));
    cyc("beq_br",    BR, 3'd0, 0, 1, 1, e(1,0,0,0,0,0,2,0,2,1,0,1));
    cyc("bne_fetch", BR, 3'd1, 0, 1, 1, e(1,1,0,0,0,2,0,2,2,0,0,2));
    cyc("bne_dec",   BR, 3'd1, 0, 1, 1, e(0,0,0,0,0,0,1,1,2,0,0,2));
    cyc("bne_br",    BR, 3'd1, 0, 1, 1, e(0,0,0,0,0,0,2,0,2,1,0,2));
    cyc("lui_fetch", LU, 3'd5, 0, 0, 1, e(1,1,0,0,0,2,0,2,3,0,0,3));
    cyc("lui_dec",   LU, 3'd5, 0, 0, 1, e(0,0,0,0,0,0,1,1,3,0,0,3));
    cyc("lui_utype", LU, 3'd5, 0, 0, 1, e(0,0,0,0,0,0,1,1,3,9,0,3));
    cyc("lui_wb",    LU, 3'd5, 0, 0, 1, e(0,0,0,1,0,0,0,0,3,0,0,3));
    cyc("bad_fetch", BAD, 3'd0, 0, 0, 1, e(1,1,0,0,0,2,0,2,0,0,0,4));
    cyc("bad_dec",   BAD, 3'd0, 0, 0, 1, e(0,0,0,0,0,0,1,1,0,0,0,4));
    cyc("bad_err",   BAD, 3'd0, 0, 0, 1, e(0,0,0,0,0,0,0,0,0,0,1,4));
    cyc("sub_fetch", RT, 3'd0, 1, 0, 1, e(1,1,0,0,0,2,0,2,0,0,0,4));
    cyc("sub_dec",   RT, 3'd0, 1, 0, 1, e(0,0,0,0,0,0,1,1,0,0,0,4));
    cyc("sub_exec",  RT, 3'd0, 1, 0, 1, e(0,0,0,0,0,0,2,0,0,1,0,4));
    cyc("sub_wb",    RT, 3'd0, 1, 0, 1, e(0,0,0,1,0,0,0,0,0,0,0,4));
    cyc("srai_fetch", IT, 3'd5, 1, 0, 1, e(1,1,0,0,0,2,0,2,0,0,0,5));
    cyc("srai_dec",   IT, 3'd5, 1, 0, 1, e(0,0,0,0,0,0,1,1,0,0,0,5));
    cyc("srai_exec",  IT, 3'd5, 1, 0, 1, e(0,0,0,0,0,0,2,1,0,4'hB,0,5));
    cyc("srai_wb",    IT, 3'd5, 1, 0, 1, e(0,0,0,1,0,0,0,0,0,0,0,5));
    cyc("jal_fetch", JL, 3'd0, 0, 0, 1, e(1,1,0,0,0,2,0,2,4,0,0,6));
    cyc("jal_dec",   JL, 3'd0, 0, 0, 1, e(0,0,0,0,0,0,1,1,4,0,0,6));
    cyc("jal_exec",  JL, 3'd0, 0, 0, 1, e(1,0,0,0,0,0,1,2,4,0,0,6));
    cyc("jal_wb",    JL, 3'd0, 0, 0, 1, e(0,0,0,1,0,0,0,0,4,0,0,6));
    cyc("sw_fetch",  SW, 3'd2, 0, 0, 1, e(1,1,0,0,0,2,0,2,1,0,0,7));
    cyc("sw_dec",    SW, 3'd2, 0, 0, 1, e(0,0,0,0,0,0,1,1,1,0,0,7));
    cyc("sw_adr",    SW, 3'd2, 0, 0, 1, e(0,0,0,0,0,0,2,1,1,0,0,7));
    cyc("sw_wait",   SW, 3'd2, 0, 0, 0, e(0,0,0,0,1,0,0,0,1,0,0,7));
    cyc("sw_write",  SW, 3'd2, 0, 0, 1, e(0,0,1,0,1,0,0,0,1,0,0,7));
    #6;
    rst_n = 0;
    #1;
    check_en("reset_mid_write", {PCWrite, IRWrite, MemWrite, RegWrite, illegal, instret}, 37'd0);
    op = LW; mem_ready = 0;
    #1;
    rst_n = 1;
    cyc("post_reset_fetch", LW, 3'd2, 0, 0, 0, e(0,0,0,0,0,2,0,2,0,0,0,0));
    repeat (2) @(posedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 Parameter RESET_STATE, default S_FETCH, selects the state entered on reset; only S_FETCH is supported.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 op  input  7  instruction opcode, instr[6:0], from the instruction register.
REQ-005 funct3  input  3  instr[14:12].
REQ-006 funct7b5  input  1  instr[30].
REQ-007 zero  input  1  ALU zero flag, valid in S_BRANCH.
REQ-008 mem_ready  input  1  memory handshake; access completes in the cycle it is 1.
REQ-009 PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc  output  1 each  datapath enables/select.
REQ-010 ResultSrc, ALUSrcA, ALUSrcB  output  2 each  mux selects.
REQ-011 ImmSrc  output  3  immediate format: I=000, S=001, B=010, U=011, J=100.
REQ-012 ALUControl  output  4  ALU operation code.
REQ-013 illegal  output  1  one-cycle pulse on an unsupported opcode.
REQ-014 instret  output  32  retired-instruction count.

Function
REQ-015 Moore FSM; datapath outputs decode from the state register only, except PCWrite, IRWrite and MemWrite, which are also gated by mem_ready, zero and funct3.
REQ-016 States and next state from S_FETCH are fixed:
- S_FETCH -> S_DECODE when mem_ready=1; otherwise hold.
- S_DECODE -> by op: 0000011/0100011 S_MEMADR; 0110011 S_EXECR; 0010011 S_EXECI; 1101111 S_JAL; 1100011 S_BRANCH; 1100111 S_JALR; 0010111/0110111 S_UTYPE; any other op S_ERROR.
REQ-017 Transitions from S_MEMADR onward are fixed:
- S_MEMADR -> S_MEMREAD (load) or S_MEMWRITE (store).
- S_MEMREAD -> S_MEMWB when mem_ready=1; otherwise hold.
- S_MEMWRITE -> S_FETCH when mem_ready=1; otherwise hold.
- S_EXECR, S_EXECI, S_JAL, S_UTYPE -> S_ALUWB.
- S_JALR -> S_JALRWB.
- S_MEMWB, S_ALUWB, S_BRANCH, S_JALRWB, S_ERROR -> S_FETCH.
REQ-018 Selects per state (ALUSrcA/ALUSrcB/ALUOp/ResultSrc, AdrSrc=0 unless listed):
- S_FETCH 00/10/00/10; IRWrite=mem_ready; PC update=mem_ready.
- S_DECODE 01/01/00.
- S_MEMADR 10/01/00.
- S_MEMREAD ResultSrc=00, AdrSrc=1.
- S_MEMWRITE ResultSrc=00, AdrSrc=1, MemWrite=mem_ready.
- S_MEMWB ResultSrc=01, RegWrite=1.
- S_EXECR 10/00/10.
- S_EXECI 10/01/10.
- S_ALUWB ResultSrc=00, RegWrite=1.
- S_JAL 01/10/00/00; PC update.
- S_BRANCH 10/00/01/00.
- S_JALR 10/01/00/10; PC update.
- S_JALRWB 01/10/00/10, RegWrite=1.
- S_UTYPE 01/01/11.
- S_ERROR: all enables 0, illegal=1.
REQ-019 PCWrite = PC update OR (S_BRANCH AND (funct3=000 ? zero : funct3=001 ? ~zero : 0)).
REQ-020 ALUControl decode:
- ALUOp 00 gives 0000; ALUOp 01 gives 0001.
- ALUOp 10 maps funct3 000..111 to 0000/0001, 1010, 0101, 0110, 0100, 1011/1100, 0011, 0010.
- Within ALUOp 10: SUB (0001) only when funct7b5=1 and op[5]=1; SRA (1011) when funct7b5=1, otherwise SRL (1100).
- ALUOp 11 gives 1000 for op=0010111 and 1001 for op=0110111; funct3 is ignored for U-type.
REQ-021 ImmSrc decodes combinationally from op in every state; unsupported op gives 000.
REQ-022 instret increments by 1, wrapping 0xFFFFFFFF->0, on each transition to S_FETCH except the one from S_ERROR.

Reset
REQ-023 rst_n=0 forces state=S_FETCH and instret=0 immediately, without waiting for clk.
REQ-024 While rst_n=0, PCWrite, IRWrite, MemWrite, RegWrite and illegal SHALL be 0, including when reset asserts mid-access.
REQ-025 The first fetch begins on the first rising edge after rst_n deasserts.

Structure
REQ-026 Package riscv_ctrl_pkg SHALL hold the state encoding (4-bit), opcode constants, ALUOp codes and ImmSrc codes.
REQ-027 The ALUControl decode SHALL be the team's existing ALU_Decoder, instantiated as the one sub-module; the FSM stays in multicycle_controller.

Verification
REQ-028 lw (op=0000011), mem_ready=1: five states FETCH-DECODE-MEMADR-MEMREAD-MEMWB; RegWrite=1 only in MEMWB with ResultSrc=01; instret 0->1.
REQ-029 mem_ready=0 for 3 cycles in S_FETCH: state holds with IRWrite=0 and PCWrite=0; on the 4th cycle, mem_ready=1 gives IRWrite=1 and S_DECODE next.
REQ-030 Branch: beq zero=1 gives PCWrite=1 in S_BRANCH; bne (funct3=001) zero=1 gives PCWrite=0; ALUControl=0001 in both.
REQ-031 lui (op=0110111, funct3=101): S_UTYPE with ALUOp=11, ALUControl=1001, ImmSrc=011, then S_ALUWB RegWrite=1.
REQ-032 op=1111111: S_ERROR with illegal=1 for one cycle, then S_FETCH; instret unchanged.
REQ-033 rst_n low mid S_MEMWRITE with mem_ready=1: MemWrite drops to 0 at once; after release state=S_FETCH and instret=0.
